pipelined_adder: RTL and testbench
==================================

// Module: pipelined_adder
// PURPOSE
//  Parametrised, pipelined WIDTH-bit adder/subtractor: successor to the single-bit full adder.
//  Carry chain split into STAGES equal segments, one register per segment.
//  Valid/ready handshake on both sides with full backpressure.
//  Datapath primitive for the JTAG TAP data-register arithmetic and for testbench scoreboards.
// PARAMETERS
//  WIDTH   16  operand width in bits; must be >= 1 and divisible by STAGES
//  STAGES  4   pipeline depth = latency in cycles; 1..WIDTH; SEG = WIDTH/STAGES bits per stage
// PORTS
//  input_clk        in   1      clock; all state on rising edge
//  input_rst_n      in   1      asynchronous, active-low reset
//  input_valid      in   1      operand beat offered
//  input_ready_o    out  1      block accepts beat this cycle (input_valid & input_ready_o)
//  input_a          in   WIDTH  operand A
//  input_b          in   WIDTH  operand B
//  input_cin        in   1      carry in (ADD only)
//  input_mode       in   1      0 = ADD, 1 = SUB
//  output_valid_o   out  1      result beat presented
//  output_ready     in   1      downstream accepts result (output_valid_o & output_ready)
//  output_sum_o     out  WIDTH  result bits
//  output_cout_o    out  1      carry out of MSB (SUB: 1 = no borrow)
//  output_ovf_o     out  1      two's-complement signed overflow
// BEHAVIOUR
//  Reset (async assert, sync release): all stage valids 0, all data registers 0;
//   output_valid_o=0, output_sum_o=0, output_cout_o=0, output_ovf_o=0.
//  Arithmetic: ADD {cout,sum} = a + b + cin; SUB {cout,sum} = a + ~b + 1 (cin ignored).
//   ovf = (a_msb == b'_msb) & (sum_msb != a_msb), b' = operand after SUB inversion.
//   Results mod 2^WIDTH; cout is bit WIDTH.
//  Pipeline: stage k (k=1..STAGES) holds v[k], the carry into segment k, sum bits [k*SEG-1:0],
//   the unconsumed high bits of a and b', and b'_msb.
//   Logic into stage k adds segment k-1 only: combinational depth is SEG full adders.
//  Latency: exactly STAGES cycles from accept to output_valid_o when not stalled;
//   throughput is 1 beat/cycle.
//  Handshake: adv[k] = v[k] & (k==STAGES ? output_ready : ~v[k+1] | adv[k+1]).
//   Stage k loads when ~v[k] | adv[k]; it then clears if nothing advances in.
//   input_ready_o = ~v[1] | adv[1]; combinational from output_ready, with no registered skid.
//  Stall: output_valid_o & ~output_ready holds all outputs stable and bubbles compress upstream.
//   No beat is dropped or duplicated; ordering is strictly FIFO.
//  Simultaneous accept and emit while full: both occur in the same cycle.
//  STAGES=1: a single register stage, equivalent to a registered WIDTH-bit ripple adder.
//  Reset mid-operation: all in-flight beats are discarded; output_valid_o falls immediately (async).
//  input_* data are don't-care when input_valid=0; nothing is loaded on an unaccepted cycle.
// STRUCTURE
//  Shared package: MODE_ADD=1'b0, MODE_SUB=1'b1 constants.
//  Sub-module adder_segment #(SEG): a+b+cin over SEG bits -> sum, cout, carry-into-MSB.
//   Built as a ripple chain; the overflow term is used only at the final segment.
//  Top: generate loop of STAGES segments plus registers and valid/advance chain; elaboration check on WIDTH%STAGES.
// TESTING (WIDTH=8, STAGES=4 unless stated)
//  Reset: hold input_rst_n=0 with random inputs -> all outputs 0, input_ready_o=1.
//  ADD 0xFF+0x01, cin=0 -> 4 cycles later sum=0x00, cout=1, ovf=0.
//   Also 0x7F+0x01 -> sum=0x80, ovf=1.
//  SUB 0x05-0x07 -> sum=0xFE, cout=0, ovf=0; SUB 0x80-0x01 -> sum=0x7F, cout=1, ovf=1; cin=1 ignored.
//  Streaming 100 back-to-back random beats with output_ready=1 -> one result per cycle.
//   Results in order and match the reference model; input_ready_o stays 1.
//  Backpressure: output_ready=0 for 10 cycles while driving beats -> exactly 4 accepted.
//   Outputs stable while stalled; release drains all 4 in order.
//  Reset mid-stream with 3 beats in flight -> output_valid_o=0 at once; after release, no stale beats emerge.
//   Repeat ADD/SUB corner cases with STAGES=1 and STAGES=8.

Source files
------------

// File: rtl/pipelined_adder_pkg.sv
// Shared constants for the pipelined adder/subtractor.
// Operation select encoding used by the datapath and its users.
package pipelined_adder_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/pipelined_adder_segment.sv
// One carry-chain segment of the pipelined adder.
// Ripple a+b+cin over SEG bits; also exposes the carry into the MSB.
module adder_segment #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           cmsb
);

  logic [SEG:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < SEG; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[SEG];
  assign cmsb = c[SEG-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor, one carry segment per stage.
// Valid/ready on both sides; stall propagates back with bubble compression.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             input_clk,
  input  logic             input_rst_n,
  input  logic             input_valid,
  output logic             input_ready_o,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  input  logic             input_cin,
  input  logic             input_mode,
  output logic             output_valid_o,
  input  logic             output_ready,
  output logic [WIDTH-1:0] output_sum_o,
  output logic             output_cout_o,
  output logic             output_ovf_o
);

  localparam int SEG = WIDTH / STAGES;

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a multiple of STAGES");
  end

  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] vin, en;
  logic [STAGES:0]   room;

  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic             c_q   [STAGES];
  logic [WIDTH-1:0] a_d   [STAGES];
  logic [WIDTH-1:0] b_d   [STAGES];
  logic [WIDTH-1:0] s_d   [STAGES];
  logic             c_d   [STAGES];
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] a_src [STAGES];
  logic [WIDTH-1:0] b_src [STAGES];
  logic [WIDTH-1:0] s_src [STAGES];
  logic             c_src [STAGES];

  logic [SEG-1:0]   seg_s  [STAGES];
  logic             seg_co [STAGES];
  logic             seg_cm [STAGES];

  // room[k]: stage k can take a beat this cycle; room[STAGES] is the sink
  always_comb begin
    room         = '0;
    vin          = '0;
    en           = '0;
    v_d          = v_q;
    room[STAGES] = output_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      room[k] = ~v_q[k] | (v_q[k] & room[k+1]);
    end
    vin[0] = input_valid;
    for (int k = 1; k < STAGES; k++) begin
      vin[k] = v_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      en[k] = room[k] & vin[k];
      if (room[k]) begin
        v_d[k] = vin[k];
      end
    end
  end

  assign input_ready_o = room[0];

  always_comb begin
    a_src[0] = input_a;
    b_src[0] = (input_mode == MODE_SUB) ? ~input_b : input_b;
    c_src[0] = (input_mode == MODE_SUB) ? 1'b1 : input_cin;
    s_src[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      a_src[k] = a_q[k-1];
      b_src[k] = b_q[k-1];
      c_src[k] = c_q[k-1];
      s_src[k] = s_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    adder_segment #(
      .SEG (SEG)
    ) u_seg (
      .a    (a_src[k][SEG-1:0]),
      .b    (b_src[k][SEG-1:0]),
      .cin  (c_src[k]),
      .sum  (seg_s[k]),
      .cout (seg_co[k]),
      .cmsb (seg_cm[k])
    );
  end

  // Operands shift down as they are consumed; sum fills in from the top
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      a_d[k] = a_q[k];
      b_d[k] = b_q[k];
      s_d[k] = s_q[k];
      c_d[k] = c_q[k];
      if (en[k]) begin
        a_d[k] = a_src[k] >> SEG;
        b_d[k] = b_src[k] >> SEG;
        s_d[k] = (s_src[k] >> SEG)
               | (WIDTH'(seg_s[k]) << (WIDTH - SEG));
        c_d[k] = seg_co[k];
      end
    end
    ovf_d = ovf_q;
    if (en[STAGES-1]) begin
      ovf_d = seg_cm[STAGES-1] ^ seg_co[STAGES-1];
    end
  end

  always_ff @(posedge input_clk or negedge input_rst_n) begin
    if (!input_rst_n) begin
      v_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
    end else begin
      v_q   <= v_d;
      ovf_q <= ovf_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
      end
    end
  end

  assign output_valid_o = v_q[STAGES-1];
  assign output_sum_o   = s_q[STAGES-1];
  assign output_cout_o  = c_q[STAGES-1];
  assign output_ovf_o   = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder at WIDTH=8 with 4, 1 and 8 stages.
// Expected beats come from a behavioural model queued on accept.
module tb_pipelined_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a, b;
  logic       cin, mode;
  logic       v4, v1, v8;
  logic       r4;
  logic       r1 = 1'b1;
  logic       r8 = 1'b1;

  logic       rdy4, ov4, co4, of4;
  logic [7:0] s4;
  logic       rdy1, ov1, co1, of1;
  logic [7:0] s1;
  logic       rdy8, ov8, co8, of8;
  logic [7:0] s8;

  int n_tests = 0;
  int n_fail  = 0;
  int n_emit  = 0;
  int n_acc   = 0;
  logic acc_last;
  logic [9:0] sb[$];

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(8), .STAGES(4)) u_dut4 (
    .input_clk(clk), .input_rst_n(rst_n),
    .input_valid(v4), .input_ready_o(rdy4),
    .input_a(a), .input_b(b), .input_cin(cin), .input_mode(mode),
    .output_valid_o(ov4), .output_ready(r4),
    .output_sum_o(s4), .output_cout_o(co4), .output_ovf_o(of4)
  );

  pipelined_adder #(.WIDTH(8), .STAGES(1)) u_dut1 (
    .input_clk(clk), .input_rst_n(rst_n),
    .input_valid(v1), .input_ready_o(rdy1),
    .input_a(a), .input_b(b), .input_cin(cin), .input_mode(mode),
    .output_valid_o(ov1), .output_ready(r1),
    .output_sum_o(s1), .output_cout_o(co1), .output_ovf_o(of1)
  );

  pipelined_adder #(.WIDTH(8), .STAGES(8)) u_dut8 (
    .input_clk(clk), .input_rst_n(rst_n),
    .input_valid(v8), .input_ready_o(rdy8),
    .input_a(a), .input_b(b), .input_cin(cin), .input_mode(mode),
    .output_valid_o(ov8), .output_ready(r8),
    .output_sum_o(s8), .output_cout_o(co8), .output_ovf_o(of8)
  );

  function automatic logic [9:0] model(logic [7:0] fa, logic [7:0] fb,
                                       logic fc, logic fm);
    logic [7:0] bp;
    logic [8:0] r;
    logic       c0;
    bp = fm ? ~fb : fb;
    c0 = fm ? 1'b1 : fc;
    r  = {1'b0, fa} + {1'b0, bp} + {8'b0, c0};
    return {r[8], (fa[7] == bp[7]) && (r[7] != fa[7]), r[7:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample the handshakes mid-low-phase, then advance to the next negedge
  task automatic step();
    logic [9:0] e;
    #1;
    acc_last = v4 && rdy4;
    if (acc_last) begin
      n_acc++;
      sb.push_back(model(a, b, cin, mode));
    end
    if (ov4 && r4) begin
      n_emit++;
      if (sb.size() == 0) begin
        chk("stale_out", {63'b0, ov4}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_result", {54'b0, co4, of4, s4}, {54'b0, e});
      end
    end
    @(negedge clk);
  endtask

  task automatic rand_beat();
    a    = 8'($urandom);
    b    = 8'($urandom);
    cin  = 1'($urandom);
    mode = 1'($urandom);
  endtask

  task automatic corner(input string nm, input logic [7:0] ca,
                        input logic [7:0] cb, input logic cc,
                        input logic cm, input logic [9:0] exp);
    int         lat [3];
    logic [9:0] got [3];
    logic       seen[3];
    for (int i = 0; i < 3; i++) begin
      lat[i]  = 0;
      got[i]  = '0;
      seen[i] = 1'b0;
    end
    a = ca; b = cb; cin = cc; mode = cm;
    r4 = 1'b1; v4 = 1'b1; v1 = 1'b1; v8 = 1'b1;
    step();
    v4 = 1'b0; v1 = 1'b0; v8 = 1'b0;
    rand_beat();
    for (int n = 1; n <= 12; n++) begin
      if (!seen[0] && ov4) begin
        seen[0] = 1'b1; lat[0] = n; got[0] = {co4, of4, s4};
      end
      if (!seen[1] && ov1) begin
        seen[1] = 1'b1; lat[1] = n; got[1] = {co1, of1, s1};
      end
      if (!seen[2] && ov8) begin
        seen[2] = 1'b1; lat[2] = n; got[2] = {co8, of8, s8};
      end
      step();
    end
    chk({nm, " s4 lat"}, lat[0], 4);
    chk({nm, " s4 res"}, {54'b0, got[0]}, {54'b0, exp});
    chk({nm, " s1 lat"}, lat[1], 1);
    chk({nm, " s1 res"}, {54'b0, got[1]}, {54'b0, exp});
    chk({nm, " s8 lat"}, lat[2], 8);
    chk({nm, " s8 res"}, {54'b0, got[2]}, {54'b0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, a0;
    rst_n = 1'b0;
    r4 = 1'b0; v4 = 1'b0; v1 = 1'b0; v8 = 1'b0;
    rand_beat();

    // Reset with random inputs toggling
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rand_beat();
      v4 = 1'($urandom); v1 = 1'($urandom); v8 = 1'($urandom);
      r4 = 1'($urandom);
    end
    #1;
    chk("rst ov4", ov4, 0);
    chk("rst sum4", s4, 0);
    chk("rst cout4", co4, 0);
    chk("rst ovf4", of4, 0);
    chk("rst rdy4", rdy4, 1);
    chk("rst ov1", ov1, 0);
    chk("rst ov8", ov8, 0);
    v4 = 1'b0; v1 = 1'b0; v8 = 1'b0; r4 = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    corner("add ff+01", 8'hFF, 8'h01, 1'b0, 1'b0, {1'b1, 1'b0, 8'h00});
    corner("add 7f+01", 8'h7F, 8'h01, 1'b0, 1'b0, {1'b0, 1'b1, 8'h80});
    corner("add ff+00+c", 8'hFF, 8'h00, 1'b1, 1'b0, {1'b1, 1'b0, 8'h00});
    corner("sub 05-07", 8'h05, 8'h07, 1'b0, 1'b1, {1'b0, 1'b0, 8'hFE});
    corner("sub 80-01", 8'h80, 8'h01, 1'b1, 1'b1, {1'b1, 1'b1, 8'h7F});
    chk("corner sb empty", sb.size(), 0);

    // Back-to-back streaming
    r4 = 1'b1;
    e0 = n_emit;
    for (int i = 0; i < 100; i++) begin
      rand_beat();
      v4 = 1'b1;
      step();
      if (!acc_last) chk("stream accept", {63'b0, acc_last}, 64'd1);
    end
    chk("stream accepts", n_acc, 105);
    chk("stream emits", n_emit - e0, 96);
    v4 = 1'b0;
    for (int i = 0; i < 10 && sb.size() > 0; i++) step();
    chk("stream total", n_emit - e0, 100);

    // Backpressure
    r4 = 1'b0;
    a0 = n_acc;
    e0 = n_emit;
    for (int i = 0; i < 10; i++) begin
      rand_beat();
      v4 = 1'b1;
      step();
      if (ov4 && sb.size() > 0) begin
        chk("stall hold", {54'b0, co4, of4, s4}, {54'b0, sb[0]});
      end
    end
    chk("bp accepted", n_acc - a0, 4);
    chk("bp rdy low", rdy4, 0);
    chk("bp ov high", ov4, 1);
    rand_beat();
    r4 = 1'b1;
    step();
    chk("full acc+emit", acc_last, 1);
    chk("full emit", n_emit - e0, 1);
    v4 = 1'b0;
    for (int i = 0; i < 12 && sb.size() > 0; i++) step();
    chk("bp drain", sb.size(), 0);
    chk("bp emits", n_emit - e0, 5);

    // Reset with beats in flight
    r4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_beat();
      v4 = 1'b1;
      step();
    end
    v4 = 1'b0;
    step();
    chk("pre-rst ov4", ov4, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst ov4", ov4, 0);
    chk("async rst sum4", s4, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    r4 = 1'b1;
    e0 = n_emit;
    for (int i = 0; i < 10; i++) step();
    chk("no stale beats", n_emit - e0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
